// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the CORDIC DDS pipeline: paces updates on a
// fixed sample tick, captures returned samples and steps the phase increment per dwell.
module dds_sweep_ctrl #(
  parameter int DIV = 50,
  parameter int CW  = 20
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [CW-1:0] i_f_start,
  input  logic [CW-1:0] i_f_step,
  input  logic [11:0]   i_n_steps,
  input  logic [15:0]   i_dwell,
  output logic [CW-1:0] o_dds_increment,
  output logic          o_dds_update,
  input  logic [15:0]   i_dds_q,
  input  logic          i_dds_ready,
  output logic [15:0]   o_sample,
  output logic          o_sample_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TICK     = 2'd1,
    S_WAIT_RDY = 2'd2,
    S_FIN      = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_inc;
  logic [CW-1:0] r_f_step;
  logic [11:0]   r_n_steps;
  logic [15:0]   r_dwell;
  logic [11:0]   r_step_cnt;
  logic [15:0]   r_dwell_cnt;
  logic [TW-1:0] r_tick_cnt;

  logic          w_tick;
  logic          w_dwell_last;
  logic          w_step_last;
  logic [CW-1:0] w_inc_next;

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_dwell_last = (r_dwell_cnt == (r_dwell - 16'd1));
  assign w_step_last  = (r_step_cnt == (r_n_steps - 12'd1));
  assign w_inc_next   = r_inc + r_f_step;

  // Sweep sequencer: all control state and every output register live here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_inc           <= '0;
      r_f_step        <= '0;
      r_n_steps       <= '0;
      r_dwell         <= '0;
      r_step_cnt      <= '0;
      r_dwell_cnt     <= '0;
      r_tick_cnt      <= '0;
      o_dds_increment <= '0;
      o_dds_update    <= 1'b0;
      o_sample        <= '0;
      o_sample_valid  <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_dds_update   <= 1'b0;
      o_sample_valid <= 1'b0;
      o_done         <= 1'b0;

      // Sample-tick timebase free-runs only while a sweep is active.
      if (o_busy) begin
        if (w_tick) begin
          r_tick_cnt <= '0;
        end else begin
          r_tick_cnt <= r_tick_cnt + TW'(1);
        end
      end else begin
        r_tick_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_inc       <= i_f_start;
            r_f_step    <= i_f_step;
            r_n_steps   <= i_n_steps;
            r_dwell     <= i_dwell;
            r_step_cnt  <= '0;
            r_dwell_cnt <= '0;
            r_tick_cnt  <= '0;
            o_err       <= 1'b0;
            if ((i_n_steps == 12'd0) || (i_dwell == 16'd0)) begin
              r_state <= S_FIN;
              o_done  <= 1'b1;
            end else begin
              r_state <= S_TICK;
              o_busy  <= 1'b1;
            end
          end
        end

        S_TICK: begin
          if (i_stop) begin
            r_state <= S_FIN;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end else if (w_tick) begin
            o_dds_update    <= 1'b1;
            o_dds_increment <= r_inc;
            r_state         <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          if (i_stop) begin
            r_state <= S_FIN;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end else if (i_dds_ready) begin
            o_sample       <= i_dds_q;
            o_sample_valid <= 1'b1;
            // A tick landing with ready is reused as the next update, so the
            // increment it carries must already include a pending frequency step.
            if (w_dwell_last) begin
              r_dwell_cnt <= '0;
              r_inc       <= w_inc_next;
              r_step_cnt  <= r_step_cnt + 12'd1;
              if (w_step_last) begin
                r_state <= S_FIN;
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
              end else if (w_tick) begin
                o_dds_update    <= 1'b1;
                o_dds_increment <= w_inc_next;
              end else begin
                r_state <= S_TICK;
              end
            end else begin
              r_dwell_cnt <= r_dwell_cnt + 16'd1;
              if (w_tick) begin
                o_dds_update    <= 1'b1;
                o_dds_increment <= r_inc;
              end else begin
                r_state <= S_TICK;
              end
            end
          end else if (w_tick) begin
            o_err   <= 1'b1;
            r_state <= S_FIN;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a reference timeline is derived per sweep from
// the sweep parameters and DDS latency, and a bench-side DDS responder returns samples.
module tb_dds_sweep_ctrl;

  localparam int DIV = 8;
  localparam int CW  = 20;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_stop;
  logic [CW-1:0] i_f_start, i_f_step;
  logic [11:0]   i_n_steps;
  logic [15:0]   i_dwell;
  logic [CW-1:0] o_dds_increment;
  logic          o_dds_update;
  logic [15:0]   i_dds_q;
  logic          i_dds_ready;
  logic [15:0]   o_sample;
  logic          o_sample_valid, o_busy, o_done, o_err;

  int tests = 0;
  int fails = 0;
  logic [15:0] qv [0:63];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.DIV(DIV), .CW(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_f_start(i_f_start), .i_f_step(i_f_step), .i_n_steps(i_n_steps), .i_dwell(i_dwell),
    .o_dds_increment(o_dds_increment), .o_dds_update(o_dds_update),
    .i_dds_q(i_dds_q), .i_dds_ready(i_dds_ready),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/increment"}, 32'(o_dds_increment), 32'd0);
    chk({tag, "/update"}, 32'(o_dds_update), 32'd0);
    chk({tag, "/sample"}, 32'(o_sample), 32'd0);
    chk({tag, "/sample_valid"}, 32'(o_sample_valid), 32'd0);
    chk({tag, "/busy"}, 32'(o_busy), 32'd0);
    chk({tag, "/done"}, 32'(o_done), 32'd0);
    chk({tag, "/err"}, 32'(o_err), 32'd0);
  endtask

  // lat < 0: DDS never answers. stp >= 0: stop high during cycle stp.
  // mid: extra start pulse mid-sweep. ss: stop raised together with start.
  task automatic run_sweep(input string name, input logic [CW-1:0] fs, input logic [CW-1:0] fst,
                           input int n, input int d, input int lat, input int stp,
                           input bit mid, input bit ss);
    int eu_c[$];
    logic [CW-1:0] eu_v[$];
    int es_c[$];
    logic [15:0] es_v[$];
    int pend[$];
    int nn, exp_done, ridx, dn;
    bit exp_err, ovr, have_inc;
    logic [CW-1:0] last_inc;

    nn = n * d;
    ridx = 0;
    dn = 0;
    for (int i = 0; i < 64; i++) qv[i] = 16'($urandom);
    ovr = (lat < 0) || (lat + 1 > DIV);
    exp_err = 1'b0;
    if (nn == 0) begin
      exp_done = 0;
    end else if (ovr) begin
      eu_c.push_back(DIV);
      eu_v.push_back(fs);
      exp_done = 2 * DIV;
      exp_err = 1'b1;
    end else begin
      for (int j = 0; j < nn; j++) begin
        eu_c.push_back((j + 1) * DIV);
        eu_v.push_back(fs + CW'(j / d) * fst);
        es_c.push_back((j + 1) * DIV + lat + 1);
        es_v.push_back(qv[j]);
      end
      exp_done = nn * DIV + lat + 1;
    end
    if (stp >= 0 && stp + 1 <= exp_done) begin
      exp_done = stp + 1;
      exp_err = 1'b0;
      while (eu_c.size() > 0 && eu_c[$] > stp) begin
        void'(eu_c.pop_back());
        void'(eu_v.pop_back());
      end
      while (es_c.size() > 0 && es_c[$] > stp) begin
        void'(es_c.pop_back());
        void'(es_v.pop_back());
      end
    end
    have_inc = (eu_c.size() > 0);
    last_inc = have_inc ? eu_v[$] : '0;

    @(negedge clk);
    i_start = 1'b1;
    i_f_start = fs;
    i_f_step = fst;
    i_n_steps = 12'(n);
    i_dwell = 16'(d);
    i_stop = ss;
    @(negedge clk);
    i_start = 1'b0;
    i_stop = 1'b0;

    for (int rel = 0; rel <= exp_done + 3; rel++) begin
      if (rel == 0) begin
        chk({name, "/busy_at_start"}, 32'(o_busy), (nn > 0) ? 32'd1 : 32'd0);
        chk({name, "/err_at_start"}, 32'(o_err), 32'd0);
      end
      if (o_dds_update) begin
        if (eu_c.size() == 0) begin
          chk({name, "/unexpected_update_cycle"}, 32'(rel), 32'hFFFF_FFFF);
        end else begin
          chk({name, "/update_cycle"}, 32'(rel), 32'(eu_c.pop_front()));
          chk({name, "/increment"}, 32'(o_dds_increment), 32'(eu_v.pop_front()));
        end
        if (lat >= 0) pend.push_back(rel + lat);
      end
      if (o_sample_valid) begin
        if (es_c.size() == 0) begin
          chk({name, "/unexpected_sample_cycle"}, 32'(rel), 32'hFFFF_FFFF);
        end else begin
          chk({name, "/sample_cycle"}, 32'(rel), 32'(es_c.pop_front()));
          chk({name, "/sample_value"}, 32'(o_sample), 32'(es_v.pop_front()));
        end
      end
      if (o_done) begin
        dn++;
        chk({name, "/done_cycle"}, 32'(rel), 32'(exp_done));
        chk({name, "/err_at_done"}, 32'(o_err), 32'(exp_err));
        chk({name, "/busy_at_done"}, 32'(o_busy), 32'd0);
        if (have_inc) chk({name, "/increment_hold"}, 32'(o_dds_increment), 32'(last_inc));
      end
      if (pend.size() > 0 && pend[0] == rel) begin
        void'(pend.pop_front());
        i_dds_ready = 1'b1;
        i_dds_q = qv[ridx];
        ridx++;
      end else begin
        i_dds_ready = 1'b0;
        i_dds_q = 16'($urandom);
      end
      i_stop = (stp >= 0 && rel == stp);
      if (mid && rel == DIV / 2) begin
        i_start = 1'b1;
        i_f_start = ~fs;
        i_n_steps = 12'd1;
        i_dwell = 16'd1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_dds_ready = 1'b0;
    i_stop = 1'b0;
    i_start = 1'b0;
    chk({name, "/missing_updates"}, 32'(eu_c.size()), 32'd0);
    chk({name, "/missing_samples"}, 32'(es_c.size()), 32'd0);
    chk({name, "/done_pulses"}, 32'(dn), 32'd1);
    chk({name, "/err_in_idle"}, 32'(o_err), 32'(exp_err));
  endtask

  initial begin
    int nupd, nsv, r, rn, rd, rlat, rstp;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_f_start = '0;
    i_f_step = '0;
    i_n_steps = '0;
    i_dwell = '0;
    i_dds_q = '0;
    i_dds_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep("basic",        20'h01000, 20'h00800, 3, 2, 5, -1, 1'b0, 1'b0);
    run_sweep("wrap",         20'hFFC00, 20'h00800, 2, 1, 3, -1, 1'b0, 1'b0);
    run_sweep("stop_mid",     20'h00100, 20'h00100, 3, 1, 5, 2 * DIV + 2, 1'b0, 1'b0);
    run_sweep("overrun",      20'h00AAA, 20'h00010, 2, 2, -1, -1, 1'b0, 1'b0);
    run_sweep("err_clear",    20'h00200, 20'h00020, 1, 2, 2, -1, 1'b0, 1'b0);
    run_sweep("zero_steps",   20'h00300, 20'h00010, 0, 3, 2, -1, 1'b0, 1'b0);
    run_sweep("zero_dwell",   20'h00300, 20'h00010, 2, 0, 2, -1, 1'b0, 1'b0);
    run_sweep("ready_tick",   20'h0F000, 20'hFF000, 2, 2, DIV - 1, -1, 1'b0, 1'b0);
    run_sweep("start_busy",   20'h04000, 20'h00400, 2, 2, 3, -1, 1'b1, 1'b0);
    run_sweep("start_stop",   20'h05000, 20'h00500, 1, 2, 2, -1, 1'b0, 1'b1);
    run_sweep("ready_lat0",   20'h06000, 20'h00600, 2, 1, 0, -1, 1'b0, 1'b0);
    run_sweep("late_overrun", 20'h07000, 20'h00700, 2, 1, DIV, -1, 1'b0, 1'b0);

    // Reset while waiting for ready, then a stray ready in IDLE.
    @(negedge clk);
    i_start = 1'b1;
    i_f_start = 20'h12345;
    i_f_step = 20'h00001;
    i_n_steps = 12'd2;
    i_dwell = 16'd2;
    @(negedge clk);
    i_start = 1'b0;
    repeat (DIV + 2) @(negedge clk);
    chk("rst_wait/busy_before", 32'(o_busy), 32'd1);
    chk("rst_wait/inc_before", 32'(o_dds_increment), 32'h12345);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk_all_zero("rst_wait");
    nupd = 0;
    nsv = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      if (o_dds_update) nupd++;
      if (o_sample_valid) nsv++;
      i_dds_ready = (c == 2);
      i_dds_q = 16'hBEEF;
      @(negedge clk);
    end
    i_dds_ready = 1'b0;
    chk("rst_wait/updates_after", 32'(nupd), 32'd0);
    chk("rst_wait/samples_after", 32'(nsv), 32'd0);
    chk("rst_wait/sample_after", 32'(o_sample), 32'd0);

    for (int k = 0; k < 16; k++) begin
      rn = int'($urandom_range(1, 4));
      rd = int'($urandom_range(1, 3));
      r = int'($urandom_range(0, 9));
      rlat = (r == 9) ? -1 : int'($urandom_range(0, DIV));
      rstp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn * rd * DIV)) : -1;
      run_sweep($sformatf("rand%0d", k), CW'($urandom), CW'($urandom), rn, rd, rlat, rstp,
                1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
